// File: rtl/mem_redundancy_bridge_if.sv
// MCU async-SRAM bus, banked SRAM bus and error status of the
// redundancy bridge; slave is the bridge, master is its environment.
interface mem_redundancy_bridge_if #(
    parameter int DW    = 16,
    parameter int AW    = 21,
    parameter int NBANK = 2
);
    logic                mcu_cs_n;
    logic                mcu_we_n;
    logic                mcu_oe_n;
    logic [AW-1:0]       mcu_addr;
    logic [DW-1:0]       mcu_dq_i;
    logic [DW-1:0]       mcu_dq_o;
    logic                mcu_dq_oe;
    logic [2:0]          ecc_sel;
    logic [NBANK-1:0]    sram_cs_n;
    logic                sram_we_n;
    logic                sram_oe_n;
    logic [AW-1:0]       sram_addr;
    logic [NBANK*DW-1:0] sram_dq_o;
    logic [NBANK-1:0]    sram_dq_oe;
    logic [NBANK*DW-1:0] sram_dq_i;
    logic                busy;
    logic                err_mismatch;
    logic [7:0]          err_count;
    logic                err_clr;

    modport slave (
        input  mcu_cs_n, mcu_we_n, mcu_oe_n, mcu_addr, mcu_dq_i,
        input  ecc_sel, sram_dq_i, err_clr,
        output mcu_dq_o, mcu_dq_oe, sram_cs_n, sram_we_n, sram_oe_n,
        output sram_addr, sram_dq_o, sram_dq_oe,
        output busy, err_mismatch, err_count
    );

    modport master (
        output mcu_cs_n, mcu_we_n, mcu_oe_n, mcu_addr, mcu_dq_i,
        output ecc_sel, sram_dq_i, err_clr,
        input  mcu_dq_o, mcu_dq_oe, sram_cs_n, sram_we_n, sram_oe_n,
        input  sram_addr, sram_dq_o, sram_dq_oe,
        input  busy, err_mismatch, err_count
    );
endinterface

// File: rtl/mem_redundancy_bridge.sv
// Async MCU SRAM bus to N-bank SRAM bridge with mirror, dual-compare
// and triple-majority redundancy modes plus error accounting.
module mem_redundancy_bridge #(
    parameter int DW    = 16,
    parameter int AW    = 21,
    parameter int NBANK = 2,
    parameter int TACC  = 3
) (
    input logic                    clk,
    input logic                    FAB_RESET_N,
    mem_redundancy_bridge_if.slave bus
);
    localparam int BW = $clog2(NBANK);
    localparam int CW = 4;

    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_PULSE, RD_WAIT, RD_CAP, HOLD
    } state_t;

    typedef enum logic [1:0] {
        M_SINGLE, M_MIRROR, M_DUAL, M_TRIPLE
    } mode_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       sync1_q, sync2_q;
    logic             cs_s, we_s, oe_s;
    logic             start;

    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    mode_t            mode_q;
    logic [BW-1:0]    bank_q;
    logic [NBANK-1:0] tgt_q;
    logic             rd_q;
    logic [DW-1:0]    dout_q;
    logic [7:0]       ecnt_q, ecnt_d;
    logic             emm_q, emm_d;

    logic [BW-1:0]    bank_fld, bank_sel;
    logic [NBANK-1:0] one_hot, wr_mask, rd_mask;
    logic [AW-1:0]    addr_in;
    mode_t            mode_in;

    logic [4*DW-1:0]  rd_pad;
    logic [DW-1:0]    d0, d1, d2, maj, res;
    logic             cap, ev, set_mm, act;

    // Strobes are asynchronous to clk; bit order {cs, we, oe}
    always_ff @(posedge clk or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {bus.mcu_cs_n, bus.mcu_we_n, bus.mcu_oe_n};
            sync2_q <= sync1_q;
        end
    end

    assign cs_s  = sync2_q[2];
    assign we_s  = sync2_q[1];
    assign oe_s  = sync2_q[0];
    assign start = (state_q == IDLE) && !cs_s && (!we_s || !oe_s);

    always_comb begin
        bank_fld = bus.mcu_addr[AW-1 -: BW];
        bank_sel = BW'(int'(bank_fld) % NBANK);
        one_hot  = NBANK'(1) << bank_sel;
        unique case (bus.ecc_sel)
            3'd1:    mode_in = M_MIRROR;
            3'd2:    mode_in = M_DUAL;
            3'd3:    mode_in = (NBANK >= 3) ? M_TRIPLE : M_DUAL;
            default: mode_in = M_SINGLE;
        endcase
        addr_in = bus.mcu_addr;
        wr_mask = '1;
        rd_mask = one_hot;
        unique case (mode_in)
            M_SINGLE: begin
                addr_in[AW-1 -: BW] = '0;
                wr_mask             = one_hot;
            end
            M_MIRROR: rd_mask = NBANK'(1);
            M_DUAL:   rd_mask = NBANK'(3);
            M_TRIPLE: rd_mask = NBANK'(7);
            default:  rd_mask = one_hot;
        endcase
    end

    always_ff @(posedge clk or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!cs_s && !we_s)      state_d = WR_SETUP;
                else if (!cs_s && !oe_s) state_d = RD_WAIT;
            end
            WR_SETUP: begin
                cnt_d   = '0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == CW'(TACC - 1)) state_d = HOLD;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            RD_WAIT: begin
                if (cnt_q == CW'(TACC - 1)) state_d = RD_CAP;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            RD_CAP: state_d = HOLD;
            HOLD: begin
                // One access per MCU cycle: wait for cs to deassert
                if (cs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            addr_q  <= '0;
            wdata_q <= '0;
            mode_q  <= M_SINGLE;
            bank_q  <= '0;
            tgt_q   <= '0;
            rd_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            if (start) begin
                addr_q  <= addr_in;
                wdata_q <= bus.mcu_dq_i;
                mode_q  <= mode_in;
                bank_q  <= bank_sel;
                rd_q    <= we_s;
                tgt_q   <= we_s ? rd_mask : wr_mask;
            end
            if (cap) dout_q <= res;
        end
    end

    assign cap = (state_q == RD_CAP);

    always_comb begin
        rd_pad                 = '0;
        rd_pad[NBANK*DW-1:0]   = bus.sram_dq_i;
        d0                     = rd_pad[0 +: DW];
        d1                     = rd_pad[DW +: DW];
        d2                     = rd_pad[2*DW +: DW];
        maj                    = (d0 & d1) | (d0 & d2) | (d1 & d2);
        res                    = d0;
        ev                     = 1'b0;
        set_mm                 = 1'b0;
        unique case (mode_q)
            M_SINGLE: res = rd_pad[int'(bank_q)*DW +: DW];
            M_MIRROR: res = d0;
            M_DUAL: begin
                ev     = (d0 != d1);
                set_mm = ev;
            end
            M_TRIPLE: begin
                res = maj;
                ev  = (d0 != d1) || (d1 != d2);
            end
            default: res = d0;
        endcase
    end

    always_comb begin
        ecnt_d = ecnt_q;
        emm_d  = emm_q;
        if (bus.err_clr) begin
            ecnt_d = (cap && ev) ? 8'd1 : 8'd0;
            emm_d  = cap && set_mm;
        end else if (cap && ev) begin
            if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
            emm_d = emm_q | set_mm;
        end
    end

    always_ff @(posedge clk or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            ecnt_q <= '0;
            emm_q  <= 1'b0;
        end else begin
            ecnt_q <= ecnt_d;
            emm_q  <= emm_d;
        end
    end

    assign act = state_q inside {WR_SETUP, WR_PULSE, RD_WAIT, RD_CAP};

    assign bus.sram_cs_n    = act ? ~tgt_q : '1;
    assign bus.sram_we_n    = (state_q != WR_PULSE);
    assign bus.sram_oe_n    = (state_q != RD_WAIT);
    assign bus.sram_addr    = addr_q;
    assign bus.sram_dq_o    = {NBANK{wdata_q}};
    assign bus.sram_dq_oe   = (state_q inside {WR_SETUP, WR_PULSE}) ? tgt_q : '0;
    assign bus.mcu_dq_o     = dout_q;
    assign bus.mcu_dq_oe    = (state_q == HOLD) && rd_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.err_mismatch = emm_q;
    assign bus.err_count    = ecnt_q;
endmodule

// File: tb/tb_mem_redundancy_bridge.sv
// Directed bench for mem_redundancy_bridge: 2-bank and 3-bank
// instances, vector table plus reset, saturation and clear sequences.
module tb_mem_redundancy_bridge;
    localparam int DW = 16;
    localparam int AW = 21;

    logic clk = 1'b0;
    logic FAB_RESET_N;
    always #5 clk = ~clk;

    mem_redundancy_bridge_if #(.DW(DW), .AW(AW), .NBANK(2)) if2 ();
    mem_redundancy_bridge_if #(.DW(DW), .AW(AW), .NBANK(3)) if3 ();

    mem_redundancy_bridge #(.DW(DW), .AW(AW), .NBANK(2), .TACC(3)) dut2 (
        .clk(clk), .FAB_RESET_N(FAB_RESET_N), .bus(if2)
    );
    mem_redundancy_bridge #(.DW(DW), .AW(AW), .NBANK(3), .TACC(3)) dut3 (
        .clk(clk), .FAB_RESET_N(FAB_RESET_N), .bus(if3)
    );

    logic          sel3;
    logic          cs_n, we_n, oe_n, clr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, bd0, bd1, bd2;
    logic [2:0]    ecc;

    assign if2.mcu_cs_n  = sel3 | cs_n;
    assign if2.mcu_we_n  = sel3 | we_n;
    assign if2.mcu_oe_n  = sel3 | oe_n;
    assign if2.mcu_addr  = addr;
    assign if2.mcu_dq_i  = wd;
    assign if2.ecc_sel   = ecc;
    assign if2.err_clr   = !sel3 && clr;
    assign if2.sram_dq_i = {bd1, bd0};
    assign if3.mcu_cs_n  = !sel3 | cs_n;
    assign if3.mcu_we_n  = !sel3 | we_n;
    assign if3.mcu_oe_n  = !sel3 | oe_n;
    assign if3.mcu_addr  = addr;
    assign if3.mcu_dq_i  = wd;
    assign if3.ecc_sel   = ecc;
    assign if3.err_clr   = sel3 && clr;
    assign if3.sram_dq_i = {bd2, bd1, bd0};

    logic [2:0]    s_cs_n, s_dq_oe;
    logic          s_we_n, s_oe_n, s_busy, s_moe, s_mm;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_q;
    logic [7:0]    s_cnt;
    logic [31:0]   s_sdq;

    assign s_cs_n  = sel3 ? if3.sram_cs_n : {1'b1, if2.sram_cs_n};
    assign s_dq_oe = sel3 ? if3.sram_dq_oe : {1'b0, if2.sram_dq_oe};
    assign s_we_n  = sel3 ? if3.sram_we_n : if2.sram_we_n;
    assign s_oe_n  = sel3 ? if3.sram_oe_n : if2.sram_oe_n;
    assign s_busy  = sel3 ? if3.busy : if2.busy;
    assign s_moe   = sel3 ? if3.mcu_dq_oe : if2.mcu_dq_oe;
    assign s_mm    = sel3 ? if3.err_mismatch : if2.err_mismatch;
    assign s_addr  = sel3 ? if3.sram_addr : if2.sram_addr;
    assign s_q     = sel3 ? if3.mcu_dq_o : if2.mcu_dq_o;
    assign s_cnt   = sel3 ? if3.err_count : if2.err_count;
    assign s_sdq   = sel3 ? if3.sram_dq_o[31:0] : if2.sram_dq_o;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    int            m_we, m_oe;
    logic [2:0]    m_cs, m_dqoe;
    logic [AW-1:0] m_a;
    logic [31:0]   m_sdq;
    logic          m_ok, m_moe, m_mm;
    logic [DW-1:0] m_q;
    logic [7:0]    m_cnt;

    task automatic sample();
        if (!s_we_n) begin
            m_we++;
            m_sdq = s_sdq;
        end
        if (!s_oe_n) m_oe++;
        m_cs   |= ~s_cs_n;
        m_dqoe |= s_dq_oe;
        if (!(&s_cs_n)) m_a = s_addr;
    endtask

    task automatic wait_idle(output logic idle);
        idle = 1'b0;
        for (int i = 0; i < 12 && !idle; i++) begin
            @(posedge clk);
            #1;
            idle = !s_busy;
        end
    endtask

    task automatic access(input logic w, input logic [2:0] sel,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold);
        logic done, idle;
        done   = 1'b0;
        m_we   = 0;
        m_oe   = 0;
        m_cs   = '0;
        m_dqoe = '0;
        m_a    = '0;
        m_sdq  = '0;
        ecc    = sel;
        addr   = a;
        wd     = d;
        we_n   = !w;
        oe_n   = w;
        cs_n   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            sample();
            done = s_busy && (&s_cs_n) && (m_we + m_oe > 0);
        end
        m_q   = s_q;
        m_moe = s_moe;
        m_mm  = s_mm;
        m_cnt = s_cnt;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            sample();
        end
        cs_n = 1'b1;
        we_n = 1'b1;
        oe_n = 1'b1;
        wait_idle(idle);
        m_ok = done && idle;
    endtask

    typedef struct {
        string         nm;
        bit            b3;
        bit            w;
        logic [2:0]    sel;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] d0, d1, d2;
        int            hold;
        logic [2:0]    ecs;
        logic [AW-1:0] ea;
        logic [DW-1:0] eq;
        bit            emm;
        logic [7:0]    ecnt;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic found, seen_oe, idle;
        int   nok;

        vt[0]  = '{"m0_wr_b1",   1'b0, 1'b1, 3'd0, 21'h100000, 16'hA5A5,
                   16'h0000, 16'h0000, 16'h0000, 8, 3'b010, 21'h000000,
                   16'h0000, 1'b0, 8'd0};
        vt[1]  = '{"m0_rd_b0",   1'b0, 1'b0, 3'd0, 21'h000123, 16'h0000,
                   16'h1111, 16'h2222, 16'h0000, 0, 3'b001, 21'h000123,
                   16'h1111, 1'b0, 8'd0};
        vt[2]  = '{"m0_rd_b1",   1'b0, 1'b0, 3'd0, 21'h1ABCDE, 16'h0000,
                   16'h1111, 16'h2222, 16'h0000, 0, 3'b010, 21'h0ABCDE,
                   16'h2222, 1'b0, 8'd0};
        vt[3]  = '{"m1_wr_all",  1'b0, 1'b1, 3'd1, 21'h000010, 16'h5A5A,
                   16'h0000, 16'h0000, 16'h0000, 0, 3'b011, 21'h000010,
                   16'h2222, 1'b0, 8'd0};
        vt[4]  = '{"m1_rd_b0",   1'b0, 1'b0, 3'd1, 21'h000040, 16'h0000,
                   16'h3333, 16'h4444, 16'h0000, 0, 3'b001, 21'h000040,
                   16'h3333, 1'b0, 8'd0};
        vt[5]  = '{"m2_rd_mm",   1'b0, 1'b0, 3'd2, 21'h000200, 16'h0000,
                   16'h1234, 16'h1235, 16'h0000, 0, 3'b011, 21'h000200,
                   16'h1234, 1'b1, 8'd1};
        vt[6]  = '{"m2_rd_eq",   1'b0, 1'b0, 3'd2, 21'h000201, 16'h0000,
                   16'hBEEF, 16'hBEEF, 16'h0000, 0, 3'b011, 21'h000201,
                   16'hBEEF, 1'b1, 8'd1};
        vt[7]  = '{"m3_n2_dual", 1'b0, 1'b0, 3'd3, 21'h000020, 16'h0000,
                   16'h0001, 16'h0002, 16'h0000, 0, 3'b011, 21'h000020,
                   16'h0001, 1'b1, 8'd2};
        vt[8]  = '{"m5_rsv_b1",  1'b0, 1'b0, 3'd5, 21'h100007, 16'h0000,
                   16'h6666, 16'h7777, 16'h0000, 0, 3'b010, 21'h000007,
                   16'h7777, 1'b1, 8'd2};
        vt[9]  = '{"m2_wr_all",  1'b0, 1'b1, 3'd2, 21'h000055, 16'hC3C3,
                   16'h0000, 16'h0000, 16'h0000, 0, 3'b011, 21'h000055,
                   16'h7777, 1'b1, 8'd2};
        vt[10] = '{"n3_m3_maj",  1'b1, 1'b0, 3'd3, 21'h000300, 16'h0000,
                   16'h00FF, 16'h0FFF, 16'h00F0, 0, 3'b111, 21'h000300,
                   16'h00FF, 1'b0, 8'd1};
        vt[11] = '{"n3_m3_eq",   1'b1, 1'b0, 3'd3, 21'h000301, 16'h0000,
                   16'h4242, 16'h4242, 16'h4242, 0, 3'b111, 21'h000301,
                   16'h4242, 1'b0, 8'd1};
        vt[12] = '{"n3_m0_b2",   1'b1, 1'b0, 3'd0, 21'h100000, 16'h0000,
                   16'h0000, 16'h0000, 16'h2B2B, 0, 3'b100, 21'h000000,
                   16'h2B2B, 1'b0, 8'd1};
        vt[13] = '{"n3_m0_mod",  1'b1, 1'b0, 3'd0, 21'h180001, 16'h0000,
                   16'hAAAA, 16'h0000, 16'h0000, 0, 3'b001, 21'h000001,
                   16'hAAAA, 1'b0, 8'd1};
        vt[14] = '{"n3_m3_wr",   1'b1, 1'b1, 3'd3, 21'h000012, 16'h9999,
                   16'h0000, 16'h0000, 16'h0000, 0, 3'b111, 21'h000012,
                   16'hAAAA, 1'b0, 8'd1};

        FAB_RESET_N = 1'b0;
        sel3 = 1'b0;
        cs_n = 1'b0;
        we_n = 1'b1;
        oe_n = 1'b0;
        clr  = 1'b0;
        ecc  = 3'd0;
        addr = '0;
        wd   = '0;
        bd0  = '0;
        bd1  = '0;
        bd2  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n",  64'(s_cs_n), 64'h7);
        chk("rst_we_n",  64'(s_we_n), 64'h1);
        chk("rst_oe_n",  64'(s_oe_n), 64'h1);
        chk("rst_dq_oe", 64'(s_dq_oe), 64'h0);
        chk("rst_moe",   64'(s_moe), 64'h0);
        chk("rst_q",     64'(s_q), 64'h0);
        chk("rst_addr",  64'(s_addr), 64'h0);
        chk("rst_busy",  64'(s_busy), 64'h0);
        chk("rst_mm",    64'(s_mm), 64'h0);
        chk("rst_cnt",   64'(s_cnt), 64'h0);

        // Strobe already low at release: sync delay gates the start
        FAB_RESET_N = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_busy_1clk", 64'(s_busy), 64'h0);
        @(posedge clk);
        #1;
        chk("rel_busy_2clk", 64'(s_busy), 64'h0);
        @(posedge clk);
        #1;
        chk("rel_busy_3clk", 64'(s_busy), 64'h1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            found = s_moe;
        end
        chk("rel_rd_hold", 64'(found), 64'h1);
        cs_n = 1'b1;
        oe_n = 1'b1;
        wait_idle(idle);
        chk("rel_rd_idle", 64'(idle), 64'h1);

        for (int k = 0; k < 15; k++) begin
            sel3 = vt[k].b3;
            bd0  = vt[k].d0;
            bd1  = vt[k].d1;
            bd2  = vt[k].d2;
            access(vt[k].w, vt[k].sel, vt[k].a, vt[k].wd, vt[k].hold);
            chk({vt[k].nm, "_done"}, 64'(m_ok), 64'h1);
            chk({vt[k].nm, "_cs"}, 64'(m_cs), 64'(vt[k].ecs));
            chk({vt[k].nm, "_dqoe"}, 64'(m_dqoe),
                vt[k].w ? 64'(vt[k].ecs) : 64'h0);
            chk({vt[k].nm, "_we"}, 64'(m_we), vt[k].w ? 64'd3 : 64'd0);
            chk({vt[k].nm, "_oe"}, 64'(m_oe), vt[k].w ? 64'd0 : 64'd3);
            chk({vt[k].nm, "_addr"}, 64'(m_a), 64'(vt[k].ea));
            chk({vt[k].nm, "_sdq"}, 64'(m_sdq),
                vt[k].w ? 64'({vt[k].wd, vt[k].wd}) : 64'h0);
            chk({vt[k].nm, "_q"}, 64'(m_q), 64'(vt[k].eq));
            chk({vt[k].nm, "_moe"}, 64'(m_moe), 64'(!vt[k].w));
            chk({vt[k].nm, "_mm"}, 64'(m_mm), 64'(vt[k].emm));
            chk({vt[k].nm, "_cnt"}, 64'(m_cnt), 64'(vt[k].ecnt));
        end

        sel3 = 1'b0;
        bd0  = 16'h1234;
        bd1  = 16'h1235;
        nok  = 0;
        for (int k = 0; k < 260; k++) begin
            access(1'b1 ^ 1'b1, 3'd2, 21'h000400, 16'h0000, 0);
            if (!m_ok) nok++;
        end
        chk("sat_done", 64'(nok), 64'h0);
        chk("sat_cnt",  64'(s_cnt), 64'd255);
        chk("sat_mm",   64'(s_mm), 64'h1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_cnt", 64'(s_cnt), 64'h0);
        chk("clr_mm",  64'(s_mm), 64'h0);

        // err_clr landing on the same edge as a mismatch capture
        ecc     = 3'd2;
        addr    = '0;
        we_n    = 1'b1;
        oe_n    = 1'b0;
        cs_n    = 1'b0;
        found   = 1'b0;
        seen_oe = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #1;
            found   = seen_oe && s_oe_n && !(&s_cs_n);
            seen_oe = seen_oe | !s_oe_n;
        end
        chk("sim_rdcap", 64'(found), 64'h1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("sim_cnt", 64'(s_cnt), 64'h1);
        chk("sim_mm",  64'(s_mm), 64'h1);
        chk("sim_q",   64'(s_q), 64'h1234);
        cs_n = 1'b1;
        oe_n = 1'b1;
        wait_idle(idle);
        chk("sim_idle", 64'(idle), 64'h1);

        ecc   = 3'd1;
        addr  = 21'h000010;
        wd    = 16'h1111;
        we_n  = 1'b0;
        oe_n  = 1'b1;
        cs_n  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #1;
            found = !s_we_n;
        end
        chk("rwr_pulse", 64'(found), 64'h1);
        chk("rwr_cs_pre", 64'(s_cs_n), 64'h4);
        #2;
        FAB_RESET_N = 1'b0;
        #1;
        chk("rwr_we_n",  64'(s_we_n), 64'h1);
        chk("rwr_cs_n",  64'(s_cs_n), 64'h7);
        chk("rwr_busy",  64'(s_busy), 64'h0);
        chk("rwr_dq_oe", 64'(s_dq_oe), 64'h0);
        chk("rwr_addr",  64'(s_addr), 64'h0);
        chk("rwr_q",     64'(s_q), 64'h0);
        chk("rwr_mm",    64'(s_mm), 64'h0);
        chk("rwr_cnt",   64'(s_cnt), 64'h0);
        cs_n = 1'b1;
        we_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        FAB_RESET_N = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rwr_idle", 64'(s_busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_redundancy_bridge.md
MEM_REDUNDANCY_BRIDGE -- requirements
Module: mem_redundancy_bridge

Interface
REQ-001 SHALL have parameter DW, default 16: data width per bank.
REQ-002 SHALL have parameter AW, default 21: word address width.
REQ-003 SHALL have parameter NBANK, default 2, legal range 2..4: number of SRAM banks.
REQ-004 SHALL have parameter TACC, default 3, legal range 1..15: SRAM access time in clk cycles.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk in, 1, fabric clock (FAB_CCC_GL0); FAB_RESET_N in, 1, async active-low reset.
REQ-006 SHALL have MCU strobe inputs: mcu_cs_n, mcu_we_n and mcu_oe_n, each in, 1, asynchronous, active-low.
REQ-007 SHALL have MCU address and data ports: mcu_addr in AW; mcu_dq_i in DW; mcu_dq_o out DW; mcu_dq_oe out 1 (pad driver enable).
REQ-008 SHALL have mode input ecc_sel in, 3: redundancy mode, sampled at request start.
REQ-009 SHALL have SRAM control outputs: sram_cs_n out NBANK (one per bank); sram_we_n out 1; sram_oe_n out 1; sram_addr out AW.
REQ-010 SHALL have SRAM data ports: sram_dq_o out NBANK*DW; sram_dq_oe out NBANK; sram_dq_i in NBANK*DW.
REQ-011 SHALL have status outputs: busy out 1; err_mismatch out 1 (sticky); err_count out 8 (saturating corrected/mismatch count); err_clr in 1 (synchronous pulse).

Function
REQ-012 SHALL pass mcu_cs_n, mcu_we_n and mcu_oe_n each through a 2-FF synchronizer before use; mcu_addr, mcu_dq_i and ecc_sel SHALL be captured in the cycle that leaves IDLE.
REQ-013 SHALL implement FSM states IDLE, WR_SETUP, WR_PULSE, RD_WAIT, RD_CAP and HOLD.
REQ-014 SHALL transition IDLE->WR_SETUP when synced cs_n=0 and we_n=0; IDLE->RD_WAIT when synced cs_n=0, oe_n=0 and we_n=1; we_n SHALL win if both strobes are low.
REQ-015 SHALL stay 1 cycle in WR_SETUP, with sram_addr and data driven and sram_dq_oe set for the target banks.
REQ-016 SHALL stay TACC cycles in WR_PULSE with sram_we_n=0, then go to HOLD.
REQ-017 SHALL stay TACC cycles in RD_WAIT with sram_oe_n=0, then go to RD_CAP for 1 cycle, which samples sram_dq_i, resolves the result and registers mcu_dq_o.
REQ-018 SHALL go RD_CAP->HOLD; in HOLD, mcu_dq_oe SHALL be 1 for reads only, and the FSM SHALL return to IDLE when synced cs_n=1, so each MCU assertion yields exactly one SRAM access.
REQ-019 SHALL hold busy=1 in every state except IDLE.
REQ-020 SHALL in mode 0 (and in reserved modes 4..7) target a single bank selected by mcu_addr[AW-1 -: clog2(NBANK)] modulo NBANK; the remaining address bits pass through with the bank bits zeroed.
REQ-021 SHALL in mode 1 write all banks and read bank 0 only.
REQ-022 SHALL in mode 2 write all banks and read banks 0 and 1; on mismatch it SHALL return bank 0 data, set err_mismatch and increment err_count.
REQ-023 SHALL in mode 3 with NBANK>=3 write all banks, read banks 0..2 and return the bitwise majority; any disagreement SHALL increment err_count without setting err_mismatch; with NBANK=2, mode 3 SHALL behave as mode 2.
REQ-024 SHALL saturate err_count at 255; err_clr SHALL zero err_count and err_mismatch; a simultaneous err_clr and error event SHALL leave err_count=1 and apply the error's err_mismatch value.
REQ-025 SHALL keep sram_cs_n low only for targeted banks, only from WR_SETUP/RD_WAIT through the end of WR_PULSE/RD_CAP.

Reset
REQ-026 SHALL, on FAB_RESET_N=0 at any time (including mid-access), force: FSM=IDLE; sram_cs_n all 1; sram_we_n=1; sram_oe_n=1; all sram_dq_oe=0; mcu_dq_oe=0; mcu_dq_o=0; sram_addr=0; busy=0; err_mismatch=0; err_count=0; synchronizers=1.
REQ-027 SHALL, after reset release, not start an access until the synchronized strobes show cs_n=0, so a strobe that was already low is accepted no earlier than 2 clocks after release.

Verification
REQ-028 Bench SHALL cover: mode 0, NBANK=2, write 0xA5A5 at address 0x100000 -> only sram_cs_n[1] low, sram_we_n low for exactly 3 cycles, sram_addr=0x000000.
REQ-029 Bench SHALL cover: mode 2 read with bank0=0x1234 and bank1=0x1235 -> mcu_dq_o=0x1234, err_mismatch=1, err_count=1.
REQ-030 Bench SHALL cover: mode 3, NBANK=3, banks returning 0x00FF, 0x0FFF and 0x00F0 -> mcu_dq_o=0x00FF, err_count increments, err_mismatch stays 0.
REQ-031 Bench SHALL cover: 260 mismatching reads -> err_count=255; then err_clr -> err_count=0 and err_mismatch=0.
REQ-032 Bench SHALL cover: FAB_RESET_N asserted during WR_PULSE -> sram_we_n=1 and sram_cs_n all 1 immediately (asynchronously), busy=0.
REQ-033 Bench SHALL cover: mcu_cs_n held low across two TACC periods -> exactly one SRAM access, with no new access until mcu_cs_n goes high and then low again.
